// File: rtl/ntt_seq_pkg.sv
// Shared types and constants for the NTT-class command sequencer.
// Op codes follow the custom-0 funct3=011 instruction encoding.
package ntt_seq_pkg;

    localparam int N_COEFF = 256;
    localparam int LOGN    = 8;

    typedef enum logic [1:0] {
        OP_NTT    = 2'b00,
        OP_INVNTT = 2'b01,
        OP_PWAM   = 2'b10,
        OP_LPWAM  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        MODE_CT      = 2'b00,
        MODE_GS      = 2'b01,
        MODE_SCALE   = 2'b10,
        MODE_BASEMUL = 2'b11
    } bf_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Index of the final pass: INVNTT carries an extra scaling pass after its 7 GS layers.
    function automatic logic [2:0] last_pass(input op_e op);
        case (op)
            OP_NTT:    return 3'd6;
            OP_INVNTT: return 3'd7;
            default:   return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/ntt_cmd_sequencer_if.sv
// Command-side and butterfly-side handshake bundle of the NTT sequencer.
// The master modport is the sequencer; the slave modport is core plus butterfly unit.
interface ntt_cmd_sequencer_if;

    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;
    logic       busy;
    logic       done;
    logic       bf_valid;
    logic       bf_ready;
    logic [1:0] bf_mode;
    logic       bf_acc;
    logic [7:0] bf_addr_a;
    logic [7:0] bf_addr_b;
    logic [6:0] bf_zeta_idx;
    logic       bf_neg;
    logic       bf_wb;
    logic       err;

    modport master (
        input  cmd_valid, cmd_op, bf_ready, bf_wb,
        output cmd_ready, busy, done, bf_valid, bf_mode, bf_acc,
               bf_addr_a, bf_addr_b, bf_zeta_idx, bf_neg, err
    );

    modport slave (
        output cmd_valid, cmd_op, bf_ready, bf_wb,
        input  cmd_ready, busy, done, bf_valid, bf_mode, bf_acc,
               bf_addr_a, bf_addr_b, bf_zeta_idx, bf_neg, err
    );

endinterface

// File: rtl/ntt_addr_gen.sv
// Combinational schedule generator: maps (op, pass, cnt) to one butterfly or pointwise operation.
// The payload depends only on these registered inputs, so it stays stable while stalled.
module ntt_addr_gen
    import ntt_seq_pkg::*;
(
    input  op_e              op,
    input  logic [2:0]       pass,
    input  logic [6:0]       cnt,
    output logic [LOGN-1:0]  addr_a,
    output logic [LOGN-1:0]  addr_b,
    output logic [6:0]       zeta_idx,
    output logic             neg,
    output bf_mode_e         mode
);

    logic [2:0] layer;
    logic [6:0] group;
    logic [6:0] offset;
    logic [6:0] low_mask;

    always_comb begin
        mode     = MODE_CT;
        layer    = 3'd1;
        group    = '0;
        offset   = '0;
        low_mask = '0;
        addr_a   = '0;
        addr_b   = '0;
        zeta_idx = '0;
        neg      = 1'b0;

        case (op)
            OP_NTT: begin
                mode  = MODE_CT;
                layer = 3'd7 - pass;
            end
            OP_INVNTT: begin
                mode  = (pass == 3'd7) ? MODE_SCALE : MODE_GS;
                layer = pass + 3'd1;
            end
            default: begin
                mode  = MODE_BASEMUL;
            end
        endcase

        if (mode == MODE_CT || mode == MODE_GS) begin
            // Butterfly cnt splits into group (cnt >> L) and offset within a 2^L span;
            // addr_a inserts a zero bit at position L, addr_b sets it.
            low_mask = (7'd1 << layer) - 7'd1;
            group    = cnt >> layer;
            offset   = cnt & low_mask;
            addr_a   = ({1'b0, group} << ({1'b0, layer} + 4'd1)) | {1'b0, offset};
            addr_b   = addr_a | (8'd1 << layer);
            if (mode == MODE_CT)
                zeta_idx = (7'd1 << (3'd7 - layer)) + group;
            else
                zeta_idx = (7'd1 << (4'd8 - {1'b0, layer})) - 7'd1 - group;
        end else begin
            addr_a = {cnt, 1'b0};
            addr_b = {cnt, 1'b1};
            if (mode == MODE_BASEMUL) begin
                zeta_idx = 7'd64 + {1'b0, cnt[6:1]};
                neg      = cnt[0];
            end
        end
    end

endmodule

// File: rtl/ntt_cmd_sequencer.sv
// Multi-cycle sequencer for NTT / INVNTT / PWAM / LPWAM: stalls the core, streams one polynomial's
// schedule to the butterfly unit, and drains all writebacks between passes.
module ntt_cmd_sequencer
    import ntt_seq_pkg::*;
#(
    parameter int N       = 256,
    parameter int MAX_OUT = 8
)
(
    input  logic                    clk,
    input  logic                    rst,
    ntt_cmd_sequencer_if.master     bus
);

    localparam logic [6:0] CNT_LAST  = 7'(N / 2 - 1);
    localparam logic [3:0] OUT_LIMIT = 4'(MAX_OUT);

    state_e     state;
    state_e     state_next;
    op_e        op_q;
    logic [2:0] pass_q;
    logic [6:0] cnt_q;
    logic [3:0] outstanding;
    logic       err_q;

    logic       issue_valid;
    logic       load_cmd;
    logic       advance_pass;
    logic       handshake;
    logic       in_issue;

    logic [7:0] gen_addr_a;
    logic [7:0] gen_addr_b;
    logic [6:0] gen_zeta;
    logic       gen_neg;
    bf_mode_e   gen_mode;

    ntt_addr_gen u_addr_gen (
        .op       (op_q),
        .pass     (pass_q),
        .cnt      (cnt_q),
        .addr_a   (gen_addr_a),
        .addr_b   (gen_addr_b),
        .zeta_idx (gen_zeta),
        .neg      (gen_neg),
        .mode     (gen_mode)
    );

    assign handshake = issue_valid && bus.bf_ready;
    assign in_issue  = (state == ST_ISSUE);

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next   = state;
        issue_valid  = 1'b0;
        load_cmd     = 1'b0;
        advance_pass = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    state_next = ST_ISSUE;
                    load_cmd   = 1'b1;
                end
            end
            ST_ISSUE: begin
                issue_valid = (outstanding < OUT_LIMIT);
                if (issue_valid && bus.bf_ready && cnt_q == CNT_LAST)
                    state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Pass barrier: the next layer reads results of this one, so wait for every writeback.
                if (outstanding == 4'd0) begin
                    if (pass_q != last_pass(op_q)) begin
                        state_next   = ST_ISSUE;
                        advance_pass = 1'b1;
                    end else begin
                        state_next   = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= OP_NTT;
            pass_q <= '0;
            cnt_q  <= '0;
        end else if (load_cmd) begin
            op_q   <= op_e'(bus.cmd_op);
            pass_q <= '0;
            cnt_q  <= '0;
        end else if (advance_pass) begin
            pass_q <= pass_q + 3'd1;
            cnt_q  <= '0;
        end else if (handshake) begin
            cnt_q  <= cnt_q + 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            err_q       <= 1'b0;
        end else begin
            if (bus.bf_wb && outstanding == 4'd0)
                err_q <= 1'b1;
            if (handshake && !bus.bf_wb)
                outstanding <= outstanding + 4'd1;
            else if (!handshake && bus.bf_wb && outstanding != 4'd0)
                outstanding <= outstanding - 4'd1;
        end
    end

    assign bus.cmd_ready   = (state == ST_IDLE);
    assign bus.busy        = (state != ST_IDLE);
    assign bus.done        = (state == ST_DONE);
    assign bus.err         = err_q;
    assign bus.bf_valid    = issue_valid;
    assign bus.bf_mode     = in_issue ? gen_mode : MODE_CT;
    assign bus.bf_acc      = in_issue && (gen_mode == MODE_BASEMUL) && (op_q == OP_LPWAM);
    assign bus.bf_addr_a   = in_issue ? gen_addr_a : 8'd0;
    assign bus.bf_addr_b   = in_issue ? gen_addr_b : 8'd0;
    assign bus.bf_zeta_idx = in_issue ? gen_zeta : 7'd0;
    assign bus.bf_neg      = in_issue && gen_neg;

endmodule

// File: tb/tb_ntt_cmd_sequencer.sv
// Scoreboard bench for ntt_cmd_sequencer: the expected schedule comes from textbook NTT loop nests,
// a monitor compares every offered operation, and a delay line models the butterfly writebacks.
module tb_ntt_cmd_sequencer;

    localparam int MAX_OUT = 8;

    typedef struct packed {
        logic [1:0] mode;
        logic       acc;
        logic [7:0] a;
        logic [7:0] b;
        logic [6:0] zeta;
        logic       neg;
    } bf_op_t;

    logic clk;
    logic rst;

    ntt_cmd_sequencer_if bus ();

    ntt_cmd_sequencer #(.N(256), .MAX_OUT(MAX_OUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    bf_op_t     exp_q[$];
    bf_op_t     mon_act;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         hs_total = 0;
    int         done_cnt = 0;
    int         idle_cycles = 0;
    int         out_model = 0;
    int         peak = 0;
    int         exp_done = -1;
    int         wb_lat = 3;
    bit         rand_ready = 1'b0;
    logic       wb_force;
    logic [63:0] wb_sched;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Butterfly unit model: each accepted operation writes back exactly wb_lat cycles later.
    always @(posedge clk) begin
        if (rst)
            wb_sched <= '0;
        else
            wb_sched <= (wb_sched >> 1) |
                        ((bus.bf_valid && bus.bf_ready) ? (64'd1 << (wb_lat - 1)) : 64'd0);
    end

    assign bus.bf_wb = wb_sched[0] | wb_force;

    initial begin
        bus.bf_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.bf_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference schedule written as the usual Kyber-style loop nests over len/start/j.
    task automatic push_ops(input logic [1:0] op);
        bf_op_t e;
        int     k;
        e = '0;
        case (op)
            2'b00: begin
                k = 1;
                for (int len = 128; len >= 2; len = len / 2) begin
                    for (int start = 0; start < 256; start += 2 * len) begin
                        for (int j = start; j < start + len; j++) begin
                            e = '{mode: 2'd0, acc: 1'b0, a: 8'(j), b: 8'(j + len), zeta: 7'(k), neg: 1'b0};
                            exp_q.push_back(e);
                        end
                        k++;
                    end
                end
            end
            2'b01: begin
                k = 127;
                for (int len = 2; len <= 128; len = len * 2) begin
                    for (int start = 0; start < 256; start += 2 * len) begin
                        for (int j = start; j < start + len; j++) begin
                            e = '{mode: 2'd1, acc: 1'b0, a: 8'(j), b: 8'(j + len), zeta: 7'(k), neg: 1'b0};
                            exp_q.push_back(e);
                        end
                        k--;
                    end
                end
                for (int i = 0; i < 128; i++) begin
                    e = '{mode: 2'd2, acc: 1'b0, a: 8'(2 * i), b: 8'(2 * i + 1), zeta: 7'd0, neg: 1'b0};
                    exp_q.push_back(e);
                end
            end
            default: begin
                for (int i = 0; i < 64; i++) begin
                    e = '{mode: 2'd3, acc: op[0], a: 8'(4 * i), b: 8'(4 * i + 1), zeta: 7'(64 + i), neg: 1'b0};
                    exp_q.push_back(e);
                    e = '{mode: 2'd3, acc: op[0], a: 8'(4 * i + 2), b: 8'(4 * i + 3), zeta: 7'(64 + i), neg: 1'b1};
                    exp_q.push_back(e);
                end
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (rst) begin
            out_model = 0;
        end else begin
            mon_act = {bus.bf_mode, bus.bf_acc, bus.bf_addr_a, bus.bf_addr_b, bus.bf_zeta_idx, bus.bf_neg};
            if (bus.bf_valid) begin
                checks++;
                if (out_model >= MAX_OUT) begin
                    errors++;
                    $display("[TB] FAIL throttle: bf_valid with %0d in flight, limit %0d", out_model, MAX_OUT);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_op: got a=%0d b=%0d, expected no operation",
                             mon_act.a, mon_act.b);
                end else begin
                    if (mon_act !== exp_q[0]) begin
                        errors++;
                        $display("[TB] FAIL payload: got mode=%0d acc=%0d a=%0d b=%0d zeta=%0d neg=%0d, expected mode=%0d acc=%0d a=%0d b=%0d zeta=%0d neg=%0d",
                                 mon_act.mode, mon_act.acc, mon_act.a, mon_act.b, mon_act.zeta, mon_act.neg,
                                 exp_q[0].mode, exp_q[0].acc, exp_q[0].a, exp_q[0].b, exp_q[0].zeta, exp_q[0].neg);
                    end
                    if (bus.bf_ready)
                        void'(exp_q.pop_front());
                end
                if (bus.bf_ready)
                    hs_total++;
            end
            if (bus.busy && !bus.bf_valid && !bus.done)
                idle_cycles++;
            if (bus.done) begin
                done_cnt++;
                if (exp_done >= 0)
                    check_output("done_cycle", cyc, exp_done);
                check_output("ops_left_at_done", exp_q.size(), 0);
            end
            if (bus.bf_valid && bus.bf_ready && !bus.bf_wb)
                out_model++;
            else if (!(bus.bf_valid && bus.bf_ready) && bus.bf_wb && out_model > 0)
                out_model--;
            if (out_model > peak)
                peak = out_model;
        end
    end

    task automatic wait_done(input int start_done, input int limit);
        int n;
        n = 0;
        while (done_cnt == start_done && n < limit) begin
            @(posedge clk);
            n++;
        end
        check_output("done_seen", done_cnt - start_done, 1);
        @(negedge clk);
        check_output("busy_after_done", bus.busy, 1'b0);
        check_output("ready_after_done", bus.cmd_ready, 1'b1);
    endtask

    task automatic apply_stimulus(input logic [1:0] op, input int lat, input bit rdy_random,
                                  input bit check_timing, input bit poke_cmd);
        int total;
        int start_hs;
        int start_done;
        int passes;
        passes      = (op == 2'b00) ? 7 : (op == 2'b01) ? 8 : 1;
        wb_lat      = lat;
        rand_ready  = rdy_random;
        peak        = 0;
        idle_cycles = 0;
        @(posedge clk);
        #1;
        push_ops(op);
        total      = exp_q.size();
        start_hs   = hs_total;
        start_done = done_cnt;
        exp_done   = check_timing ? cyc + 1 + passes * (128 + lat + 1) : -1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check_output("busy_after_accept", bus.busy, 1'b1);
        check_output("ready_low_busy", bus.cmd_ready, 1'b0);
        check_output("first_valid", bus.bf_valid, 1'b1);
        if (poke_cmd) begin
            repeat (20) @(posedge clk);
            #1;
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 2'b00;
            @(negedge clk);
            check_output("cmd_ignored_busy", bus.cmd_ready, 1'b0);
            @(posedge clk);
            #1;
            bus.cmd_valid = 1'b0;
        end
        wait_done(start_done, 5000);
        check_output("handshake_total", hs_total - start_hs, total);
        if (check_timing)
            check_output("drain_idle_cycles", idle_cycles, passes * (lat + 1));
        rand_ready = 1'b0;
    endtask

    task automatic reset_mid_ntt();
        int start_hs;
        int start_done;
        int n;
        wb_lat     = 3;
        rand_ready = 1'b0;
        exp_done   = -1;
        @(posedge clk);
        #1;
        push_ops(2'b00);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        start_hs = hs_total;
        n = 0;
        while (hs_total - start_hs < 300 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check_output("reached_op300", hs_total - start_hs, 300);
        #1;
        rst        = 1'b1;
        start_done = done_cnt;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("rst_mid_busy", bus.busy, 1'b0);
        check_output("rst_mid_ready", bus.cmd_ready, 1'b1);
        check_output("rst_mid_valid", bus.bf_valid, 1'b0);
        repeat (12) @(negedge clk);
        check_output("rst_mid_no_done", done_cnt - start_done, 0);
        exp_q.delete();
    endtask

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        wb_force      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst_cmd_ready", bus.cmd_ready, 1'b1);
        check_output("rst_busy", bus.busy, 1'b0);
        check_output("rst_done", bus.done, 1'b0);
        check_output("rst_bf_valid", bus.bf_valid, 1'b0);
        check_output("rst_payload", {bus.bf_mode, bus.bf_acc, bus.bf_addr_a, bus.bf_addr_b,
                                     bus.bf_zeta_idx, bus.bf_neg}, 32'd0);
        check_output("rst_err", bus.err, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] NTT, W=3, ready always high");
        apply_stimulus(2'b00, 3, 1'b0, 1'b1, 1'b0);
        $display("[TB] INVNTT, W=3, ready always high");
        apply_stimulus(2'b01, 3, 1'b0, 1'b1, 1'b0);
        $display("[TB] LPWAM, W=4, random ready stalls");
        apply_stimulus(2'b11, 4, 1'b1, 1'b0, 1'b1);
        $display("[TB] PWAM, W=20, in-flight limit");
        apply_stimulus(2'b10, 20, 1'b0, 1'b0, 1'b0);
        check_output("peak_in_flight", peak, MAX_OUT);
        $display("[TB] NTT reset at op 300, then PWAM");
        reset_mid_ntt();
        apply_stimulus(2'b10, 3, 1'b0, 1'b1, 1'b0);

        $display("[TB] stray writeback");
        check_output("err_before_stray", bus.err, 1'b0);
        @(posedge clk);
        #1;
        wb_force = 1'b1;
        @(posedge clk);
        #1;
        wb_force = 1'b0;
        @(negedge clk);
        check_output("err_set", bus.err, 1'b1);
        repeat (5) @(negedge clk);
        check_output("err_sticky", bus.err, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("err_cleared_by_rst", bus.err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
